// File: rtl/regfile_mp.sv
// Two-write, two-read register file with a post-reset clear sequence.
// After reset, every entry is zeroed one per cycle while busy is high.
// In READY, writes to the same address are port-1-wins, and reads are
// combinational. A read that matches an in-flight write returns that
// write's data in the same cycle.
module regfile_mp #(
  parameter int XLEN    = 64,
  parameter int AW      = 5,
  parameter int ZERO_R0 = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wen0,
  input  logic [AW-1:0]   wa0,
  input  logic [XLEN-1:0] wd0,
  input  logic            wen1,
  input  logic [AW-1:0]   wa1,
  input  logic [XLEN-1:0] wd1,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            busy
);

  localparam int NREG = 2**AW;

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t            r_state, w_state_nxt;
  logic [AW-1:0]     r_idx, w_idx_nxt;
  logic [XLEN-1:0]   r_mem [NREG];
  logic              w_we0, w_we1;

  // State and clear-index register; reset restarts the clear from entry 0
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_CLEAR;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next-state: walk the index through every entry, then go READY
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    if (r_state == S_CLEAR) begin
      w_idx_nxt = r_idx + 1'b1;
      if (r_idx == '1) w_state_nxt = S_READY;
    end
  end

  // Effective write enables: only in READY, outside reset, and not to a hardwired zero entry
  always_comb begin
    w_we0 = (r_state == S_READY) && !rst && wen0 && !((ZERO_R0 != 0) && (wa0 == '0));
    w_we1 = (r_state == S_READY) && !rst && wen1 && !((ZERO_R0 != 0) && (wa1 == '0));
  end

  // Storage: clear one entry per cycle, or perform port writes (port 1 assigned last so it wins)
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == S_CLEAR) begin
        r_mem[r_idx] <= '0;
      end else begin
        if (w_we0) r_mem[wa0] <= wd0;
        if (w_we1) r_mem[wa1] <= wd1;
      end
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] rs);
    if (r_state == S_CLEAR)                 return '0;
    if ((ZERO_R0 != 0) && (rs == '0))       return '0;
    if (w_we1 && (wa1 == rs))               return wd1;
    if (w_we0 && (wa0 == rs))               return wd0;
    return r_mem[rs];
  endfunction

  // Combinational read ports with same-cycle write bypass
  always_comb begin
    rd1  = read_port(rs1);
    rd2  = read_port(rs2);
    busy = (r_state == S_CLEAR);
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized + directed bench for regfile_mp against an array-based model.
module tb_regfile_mp;

  logic        clk;
  logic        rst, wen0, wen1;
  logic [4:0]  wa0, wa1, rs1, rs2;
  logic [63:0] wd0, wd1, rd1, rd2;
  logic        busy;

  logic        s_rst, s_wen0, s_wen1;
  logic [2:0]  s_wa0, s_wa1, s_rs1, s_rs2;
  logic [31:0] s_wd0, s_wd1, s_rd1, s_rd2;
  logic        s_busy;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 0;

  logic [63:0] m_mem [32];
  int          m_left = 32;

  regfile_mp dut (
    .clk(clk), .rst(rst),
    .wen0(wen0), .wa0(wa0), .wd0(wd0),
    .wen1(wen1), .wa1(wa1), .wd1(wd1),
    .rs1(rs1), .rs2(rs2), .rd1(rd1), .rd2(rd2), .busy(busy)
  );

  regfile_mp #(.XLEN(32), .AW(3), .ZERO_R0(1)) dut_s (
    .clk(clk), .rst(s_rst),
    .wen0(s_wen0), .wa0(s_wa0), .wd0(s_wd0),
    .wen1(s_wen1), .wa1(s_wa1), .wd1(s_wd1),
    .rs1(s_rs1), .rs2(s_rs2), .rd1(s_rd1), .rd2(s_rd2), .busy(s_busy)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected read value straight from the rules: busy reads 0, entry 0 reads 0,
  // an active write to the address forwards (port 1 first), else stored value.
  function automatic logic [63:0] exp_rd(input logic [4:0] rs);
    if (m_left > 0)                        return 64'd0;
    if (rs == 5'd0)                        return 64'd0;
    if (!rst && wen1 && wa1 == rs)         return wd1;
    if (!rst && wen0 && wa0 == rs)         return wd0;
    return m_mem[rs];
  endfunction

  task automatic settle();
    @(negedge clk);
    if (chk_en) begin
      check_eq("busy", {63'd0, busy}, {63'd0, (m_left > 0)});
      check_eq("rd1", rd1, exp_rd(rs1));
      check_eq("rd2", rd2, exp_rd(rs2));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_left = 32;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) for (int i = 0; i < 32; i++) m_mem[i] = 64'd0;
    end else begin
      if (wen0 && wa0 != 5'd0) m_mem[wa0] = wd0;
      if (wen1 && wa1 != 5'd0) m_mem[wa1] = wd1;
    end
    chk_en = 1;
    #1;
  endtask

  task automatic count_busy(input string tag);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      settle();
      if (busy) cnt++;
      tick();
    end
    check_eq(tag, cnt, 32);
  endtask

  initial begin
    int cnt;
    rst = 1; wen0 = 0; wen1 = 0; wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; rs1 = 0; rs2 = 0;
    s_rst = 1; s_wen0 = 0; s_wen1 = 0; s_wa0 = 0; s_wa1 = 0; s_wd0 = 0; s_wd1 = 0;
    s_rs1 = 0; s_rs2 = 0;
    for (int i = 0; i < 32; i++) m_mem[i] = 64'd0;

    // One-cycle reset, then busy for exactly 32 cycles; everything reads 0
    settle(); tick();
    rst = 0;
    count_busy("busy_len_default");
    for (int a = 0; a < 32; a++) begin
      rs1 = 5'(a); rs2 = 5'(31 - a);
      settle();
      check_eq("clear_rd1", rd1, 64'd0);
      check_eq("clear_rd2", rd2, 64'd0);
      tick();
    end

    // Bypass then stored value
    wen0 = 1; wa0 = 3; wd0 = 64'd3; rs1 = 3;
    settle(); check_eq("bypass_rd1", rd1, 64'd3); tick();
    wen0 = 0;
    settle(); check_eq("stored_rd1", rd1, 64'd3); tick();

    // Same-address double write: port 1 wins
    wen0 = 1; wa0 = 7; wd0 = 64'hAA; wen1 = 1; wa1 = 7; wd1 = 64'h55; rs1 = 7;
    settle(); check_eq("prio_bypass", rd1, 64'h55); tick();
    wen0 = 0; wen1 = 0;
    settle(); check_eq("prio_stored", rd1, 64'h55); tick();

    // Writes to entry 0 are dropped
    wen1 = 1; wa1 = 0; wd1 = 64'hFF; rs2 = 0;
    settle(); check_eq("r0_bypass", rd2, 64'd0); tick();
    wen1 = 0;
    settle(); check_eq("r0_stored", rd2, 64'd0); tick();

    // Reset mid-clear restarts the full sequence
    wen0 = 1; wa0 = 2; wd0 = 64'd5; rs1 = 2;
    settle(); tick();
    wen0 = 0;
    settle(); check_eq("e2_written", rd1, 64'd5); tick();
    rst = 1; settle(); tick(); rst = 0;
    for (int i = 0; i < 10; i++) begin settle(); tick(); end
    rst = 1; settle(); tick(); rst = 0;
    count_busy("busy_len_restart");
    rs1 = 2;
    settle(); check_eq("e2_cleared", rd1, 64'd0); tick();

    // Randomized traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      rst  = ($urandom % 100) == 0;
      wen0 = $urandom % 2;
      wen1 = $urandom % 2;
      wa0  = 5'($urandom);
      wa1  = (($urandom % 4) == 0) ? wa0 : 5'($urandom);
      wd0  = {$urandom, $urandom};
      wd1  = {$urandom, $urandom};
      rs1  = (($urandom % 3) == 0) ? wa0 : 5'($urandom);
      rs2  = (($urandom % 3) == 0) ? wa1 : 5'($urandom);
      settle(); tick();
    end
    rst = 0; wen0 = 0; wen1 = 0;

    // Small build: writes during clear are ignored, busy lasts 8 cycles
    s_rst = 1; settle(); tick(); s_rst = 0;
    s_wen0 = 1; s_wen1 = 1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      s_wa0 = 3'($urandom); s_wa1 = 3'($urandom);
      s_wd0 = $urandom | 32'h1; s_wd1 = $urandom | 32'h1;
      settle();
      if (s_busy) cnt++;
      else begin s_wen0 = 0; s_wen1 = 0; end
      tick();
    end
    check_eq("busy_len_small", cnt, 8);
    for (int a = 0; a < 8; a++) begin
      s_rs1 = 3'(a); s_rs2 = 3'(7 - a);
      settle();
      check_eq("small_rd1", {32'd0, s_rd1}, 64'd0);
      check_eq("small_rd2", {32'd0, s_rd2}, 64'd0);
      check_eq("small_busy", {63'd0, s_busy}, 64'd0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL provide parameter XLEN, default 64, data width in bits.
REQ-002 SHALL provide parameter AW, default 5, address width; NREG = 2**AW entries.
REQ-003 SHALL provide parameter ZERO_R0, default 1, entry 0 hardwired to zero when 1.
REQ-004 SHALL provide clk  input  1  rising-edge clock, sole clock domain.
REQ-005 SHALL provide rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL provide wen0  input  1  write enable, port 0.
REQ-007 SHALL provide wa0  input  AW  write address, port 0.
REQ-008 SHALL provide wd0  input  XLEN  write data, port 0.
REQ-009 SHALL provide wen1, wa1, wd1  input  1/AW/XLEN  write port 1, same meaning.
REQ-010 SHALL provide rs1, rs2  input  AW  read addresses.
REQ-011 SHALL provide rd1, rd2  output  XLEN  read data, combinational.
REQ-012 SHALL provide busy  output  1  high while clear sequence is running.

Function
REQ-013 SHALL implement a two-state FSM, CLEAR and READY; busy = (state == CLEAR).
REQ-014 SHALL, on any rising edge with rst=1, enter CLEAR and set clear index to 0.
REQ-015 SHALL, in CLEAR with rst=0, write 0 to entry[index] each edge and increment index by 1.
REQ-016 SHALL move CLEAR->READY on the edge that clears index NREG-1; clear lasts exactly NREG cycles after rst deasserts.
REQ-017 SHALL ignore wen0/wen1 while busy=1 or rst=1.
REQ-018 SHALL drive rd1/rd2 = 0 while busy=1.
REQ-019 SHALL, in READY, write wd0 to entry[wa0] on edge when wen0=1; likewise port 1.
REQ-020 SHALL, when wen0=wen1=1 and wa0=wa1, store wd1 only (port 1 wins).
REQ-021 SHALL, when ZERO_R0=1, drop writes to address 0 and return 0 for reads of address 0.
REQ-022 SHALL bypass in READY: rsN matching an enabled, non-dropped write address returns that write data in the same cycle.
REQ-023 SHALL apply port-1 priority to bypass when both write ports match rsN.
REQ-024 SHALL otherwise return stored entry[rsN] with zero-cycle (asynchronous) read latency.
REQ-025 SHALL keep both read ports independent; rs1=rs2 returns identical data.
REQ-026 SHALL treat all addresses as unsigned, no wrap or aliasing; full 2**AW range valid.

Reset
REQ-027 SHALL restart the clear at index 0 if rst asserts mid-clear.
REQ-028 SHALL hold busy=1 for every cycle rst=1 and the following NREG cycles.
REQ-029 SHALL reach rd1=rd2=0, busy=0 and all entries 0 after completed clear.
REQ-030 SHALL leave outputs undefined before the first rst edge; simulation preload not part of this block.

Verification
REQ-031 SHALL cover: rst 1 cycle, defaults -> busy=1 exactly 32 cycles after deassert, then 0; read any address -> 0.
REQ-032 SHALL cover: READY, wen0=1 wa0=3 wd0=3, rs1=3 same cycle -> rd1=3 (bypass); next cycle wen0=0 -> rd1=3 (stored).
REQ-033 SHALL cover: wen0=1 wa0=7 wd0=0xAA and wen1=1 wa1=7 wd1=0x55 -> rd1(rs1=7)=0x55 same cycle and after.
REQ-034 SHALL cover: ZERO_R0=1, wen1=1 wa1=0 wd1=0xFF, rs2=0 -> rd2=0 same cycle and after.
REQ-035 SHALL cover: write 5 to entry 2, rst high at clear index 10 of new sequence -> busy stays 1, 32 more cycles, entry 2 reads 0.
REQ-036 SHALL cover: XLEN=32 AW=3 build, wen0=1 during busy -> ignored, busy=1 for 8 cycles, all entries 0.
